csi_pkt_parser: RTL

Parametrised CSI-2 low-level packet parser for the max10mipi receive path: consumes lane-aligned byte words from the lane deskew stage, assembles the 32-bit packet header over one or more beats, checks and optionally corrects it with the CSI-2 header ECC, and streams long-packet payload with byte enables and a last flag. Supports 1, 2 or 4 data lanes. It replaces the fixed 4-lane header resolver and adds payload streaming, footer stripping, truncation detection and error reporting.

---
 rtl/csi_pkt_parser_if.sv | 41 ++++
 rtl/csi_pkt_parser.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/csi_pkt_parser_if.sv
// csi_pkt_parser_if: stream bundle between the lane deskew stage, the packet
// parser and its consumers.
//   in_valid/in_sot/in_data : lane-aligned input beats (lane 0 in [7:0])
//   hdr_*                   : decoded packet header, pulsed by hdr_valid
//   pay_*                   : long-packet payload beats with byte enables
//   err_trunc               : burst ended inside a packet
// Modports: slave = parser view, master = source/sink view.
interface csi_pkt_parser_if #(
    parameter int LANES = 4
);
    localparam int DW = 8 * LANES;

    logic             in_valid;
    logic             in_sot;
    logic [DW-1:0]    in_data;

    logic             hdr_valid;
    logic [5:0]       hdr_dt;
    logic [1:0]       hdr_vc;
    logic [15:0]      hdr_wc;
    logic             hdr_ecc_ok;
    logic             hdr_ecc_fix;

    logic             pay_valid;
    logic [DW-1:0]    pay_data;
    logic [LANES-1:0] pay_be;
    logic             pay_last;
    logic             err_trunc;

    modport slave (
        input  in_valid, in_sot, in_data,
        output hdr_valid, hdr_dt, hdr_vc, hdr_wc, hdr_ecc_ok, hdr_ecc_fix,
        output pay_valid, pay_data, pay_be, pay_last, err_trunc
    );

    modport master (
        output in_valid, in_sot, in_data,
        input  hdr_valid, hdr_dt, hdr_vc, hdr_wc, hdr_ecc_ok, hdr_ecc_fix,
        input  pay_valid, pay_data, pay_be, pay_last, err_trunc
    );
endinterface

// File: rtl/csi_pkt_parser.sv
// csi_pkt_parser: CSI-2 low-level packet parser for 1, 2 or 4 data lanes.
// Assembles the 32-bit packet header over 4/LANES beats, checks it against
// the CSI-2 header ECC, and streams long-packet payload (footer stripped)
// with contiguous byte enables and a last flag.
// Ports:
//   clk     : byte (deskewed word) clock
//   rstn    : asynchronous active-low reset
//   bus_if  : csi_pkt_parser_if.slave (input beats, header, payload, err)
// Optional feature: define CSI_PKT_ECC_CORR_EN to correct single data-bit
// header errors; otherwise any data-bit error drops the packet.
module csi_pkt_parser #(
    parameter int         LANES     = 4,
    parameter logic [7:0] LP_DT_MAX = 8'h0F
) (
    input  logic             clk,
    input  logic             rstn,
    csi_pkt_parser_if.slave  bus_if
);
    localparam int DW = 8 * LANES;
    localparam int HB = 4 / LANES;
    localparam int CW = (HB > 1) ? $clog2(HB) : 1;

    // Syndrome contributed by each of the 24 header data bits.
    localparam logic [5:0] ECC_COL [0:23] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    typedef enum logic [1:0] {IDLE, HDR, PAY, WAIT_EOT} state_t;

    function automatic logic [5:0] ecc_calc(input logic [23:0] d);
        logic [5:0] p;
        p = '0;
        for (int i = 0; i < 24; i++)
            if (d[i]) p = p ^ ECC_COL[i];
        return p;
    endfunction

    state_t           state_q;
    logic [CW-1:0]    hb_cnt_q;
    logic [29:0]      hdr_q;      // ECC[7:6] is never stored
    logic [16:0]      rem_q;      // payload + footer bytes still to consume

    logic             hdr_valid_q, ecc_ok_q, ecc_fix_q;
    logic [5:0]       hdr_dt_q;
    logic [1:0]       hdr_vc_q;
    logic [15:0]      hdr_wc_q;
    logic             pay_valid_q, pay_last_q, trunc_q;
    logic [DW-1:0]    pay_data_q;
    logic [LANES-1:0] pay_be_q;

    // ---------------- header assembly and ECC ----------------
    logic [29:0] hdr_asm;
    logic [5:0]  syn;
    logic [23:0] d_fix;
    logic        ecc_ok, ecc_fix, is_short, hdr_done;
    int          idx;

    // Header as it will look once the current beat is written in.
    always_comb begin
        hdr_asm = hdr_q;
        idx     = 0;
        for (int b = 0; b < LANES; b++) begin
            idx = (state_q == IDLE) ? b : int'(hb_cnt_q) * LANES + b;
            if (idx < 3)
                hdr_asm[idx*8 +: 8] = bus_if.in_data[b*8 +: 8];
            else if (idx == 3)
                hdr_asm[29:24] = bus_if.in_data[b*8 +: 6];
        end
    end

    assign syn = ecc_calc(hdr_asm[23:0]) ^ hdr_asm[29:24];

    // A one-hot syndrome means the ECC byte itself took the hit, so the
    // data fields are still trustworthy.
    always_comb begin
        d_fix   = hdr_asm[23:0];
        ecc_fix = 1'b0;
        ecc_ok  = (syn == 6'd0) || $onehot(syn);
`ifdef CSI_PKT_ECC_CORR_EN
        for (int i = 0; i < 24; i++) begin
            if (syn == ECC_COL[i]) begin
                d_fix[i] = ~hdr_asm[i];
                ecc_fix  = 1'b1;
                ecc_ok   = 1'b1;
            end
        end
`endif
    end

    assign is_short = ({2'b00, d_fix[5:0]} <= LP_DT_MAX);
    assign hdr_done = bus_if.in_valid && bus_if.in_sot &&
                      ((state_q == IDLE && HB == 1) ||
                       (state_q == HDR && hb_cnt_q == CW'(HB - 1)));

    // ---------------- payload slicing ----------------
    logic [16:0]      rem_m2, rem_nx;
    logic [LANES-1:0] be_d;
    logic [DW-1:0]    data_d;
    logic             last_d;
    int               n;

    // rem counts footer too; rem-2 is what is left of the real payload.
    always_comb begin
        rem_m2 = (rem_q > 17'd2) ? rem_q - 17'd2 : '0;
        n      = (rem_m2 >= 17'(LANES)) ? LANES : int'(rem_m2);
        last_d = (rem_m2 <= 17'(LANES));
        rem_nx = (rem_q > 17'(LANES)) ? rem_q - 17'(LANES) : '0;
        be_d   = '0;
        data_d = '0;
        for (int b = 0; b < LANES; b++) begin
            be_d[b] = (b < n);
            if (b < n) data_d[b*8 +: 8] = bus_if.in_data[b*8 +: 8];
        end
    end

    // ---------------- FSM with registered outputs ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            hb_cnt_q    <= '0;
            hdr_q       <= '0;
            rem_q       <= '0;
            hdr_valid_q <= 1'b0;
            hdr_dt_q    <= '0;
            hdr_vc_q    <= '0;
            hdr_wc_q    <= '0;
            ecc_ok_q    <= 1'b0;
            ecc_fix_q   <= 1'b0;
            pay_valid_q <= 1'b0;
            pay_data_q  <= '0;
            pay_be_q    <= '0;
            pay_last_q  <= 1'b0;
            trunc_q     <= 1'b0;
        end else begin
            hdr_valid_q <= 1'b0;
            pay_valid_q <= 1'b0;
            pay_last_q  <= 1'b0;
            trunc_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus_if.in_sot && bus_if.in_valid) begin
                        hdr_q <= hdr_asm;
                        if (HB > 1) begin
                            hb_cnt_q <= CW'(1);
                            state_q  <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (!bus_if.in_sot) begin
                        trunc_q  <= 1'b1;
                        hb_cnt_q <= '0;
                        state_q  <= IDLE;
                    end else if (bus_if.in_valid) begin
                        hdr_q    <= hdr_asm;
                        hb_cnt_q <= hb_cnt_q + CW'(1);
                    end
                end
                PAY: begin
                    if (!bus_if.in_sot) begin
                        trunc_q <= 1'b1;
                        rem_q   <= '0;
                        state_q <= IDLE;
                    end else if (bus_if.in_valid) begin
                        if (rem_m2 != 17'd0) begin
                            pay_valid_q <= 1'b1;
                            pay_data_q  <= data_d;
                            pay_be_q    <= be_d;
                            pay_last_q  <= last_d;
                        end
                        rem_q <= rem_nx;
                        if (rem_nx == 17'd0) state_q <= WAIT_EOT;
                    end
                end
                WAIT_EOT: begin
                    if (!bus_if.in_sot) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Last header beat: publish fields and pick the next state.
            // A long packet with wc=0 goes through PAY with rem=2, which
            // consumes just the footer without emitting a beat.
            if (hdr_done) begin
                hdr_valid_q <= 1'b1;
                hdr_dt_q    <= d_fix[5:0];
                hdr_vc_q    <= d_fix[7:6];
                hdr_wc_q    <= d_fix[23:8];
                ecc_ok_q    <= ecc_ok;
                ecc_fix_q   <= ecc_fix;
                hb_cnt_q    <= '0;
                if (!ecc_ok || is_short) begin
                    state_q <= WAIT_EOT;
                end else begin
                    state_q <= PAY;
                    rem_q   <= {1'b0, d_fix[23:8]} + 17'd2;
                end
            end
        end
    end

    assign bus_if.hdr_valid   = hdr_valid_q;
    assign bus_if.hdr_dt      = hdr_dt_q;
    assign bus_if.hdr_vc      = hdr_vc_q;
    assign bus_if.hdr_wc      = hdr_wc_q;
    assign bus_if.hdr_ecc_ok  = ecc_ok_q;
    assign bus_if.hdr_ecc_fix = ecc_fix_q;
    assign bus_if.pay_valid   = pay_valid_q;
    assign bus_if.pay_data    = pay_data_q;
    assign bus_if.pay_be      = pay_be_q;
    assign bus_if.pay_last    = pay_last_q;
    assign bus_if.err_trunc   = trunc_q;
endmodule
